// File: rtl/store_kernal_if.sv
// Bundle between the write-back engine, the register-file read port and the BRAM write port.
// The master side is the NPU top (start/size plus read data); the slave side is store_kernal.
interface store_kernal_if #(
  parameter int unsigned KERNEL_REG_ADDR_WIDTH = 6,
  parameter int unsigned BRAM_ADDR_WIDTH       = 10,
  parameter int unsigned WEIGHT_WIDTH          = 8
);
  logic                             i_start;
  logic [KERNEL_REG_ADDR_WIDTH:0]   i_element_size;
  logic [BRAM_ADDR_WIDTH-1:0]       i_bram_start_addr;
  logic [KERNEL_REG_ADDR_WIDTH-1:0] o_reg_rd_addr;
  logic [WEIGHT_WIDTH-1:0]          i_reg_data;
  logic                             o_bram_wr_en;
  logic [BRAM_ADDR_WIDTH-1:0]       o_bram_wr_addr;
  logic [WEIGHT_WIDTH-1:0]          o_bram_wr_data;
  logic                             o_busy;
  logic                             o_done;
  logic [1:0]                       o_state;

  modport master (
    output i_start, i_element_size, i_bram_start_addr, i_reg_data,
    input  o_reg_rd_addr, o_bram_wr_en, o_bram_wr_addr, o_bram_wr_data, o_busy, o_done, o_state
  );

  modport slave (
    input  i_start, i_element_size, i_bram_start_addr, i_reg_data,
    output o_reg_rd_addr, o_bram_wr_en, o_bram_wr_addr, o_bram_wr_data, o_busy, o_done, o_state
  );
endinterface

// File: rtl/store_kernal.sv
// Write-back engine: streams register-file entries 0..N-1 into BRAM starting at a given address,
// one element per clock, with a 2-cycle read/write pipeline behind the read issue.
module store_kernal #(
  parameter int unsigned KERNEL_REG_ADDR_WIDTH = 6,
  parameter int unsigned BRAM_ADDR_WIDTH       = 10,
  parameter int unsigned WEIGHT_WIDTH          = 8,
  parameter int unsigned BRAM_DEPTH            = 784
) (
  input logic           i_clk,
  input logic           i_rst,
  store_kernal_if.slave bus
);

  localparam int unsigned SizeW    = KERNEL_REG_ADDR_WIDTH + 1;
  localparam int unsigned MaxElems = 1 << KERNEL_REG_ADDR_WIDTH;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRead  = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [SizeW-1:0]                 size_in;
  logic [SizeW-1:0]                 size_q;
  logic [SizeW-1:0]                 rd_cnt_q;
  logic [BRAM_ADDR_WIDTH-1:0]       wr_addr_q;
  logic                             rd_valid_q;
  logic                             data_valid_q;
  logic                             accept;
  logic                             issue;

  logic [KERNEL_REG_ADDR_WIDTH-1:0] rd_addr_q;
  logic                             wr_en_q;
  logic [BRAM_ADDR_WIDTH-1:0]       wr_addr_out_q;
  logic [WEIGHT_WIDTH-1:0]          wr_data_q;
  logic                             busy_d, busy_q;
  logic                             done_d, done_q;

  assign accept  = (state_q == StIdle) && bus.i_start;
  assign issue   = (state_q == StRead) && (rd_cnt_q != size_q);
  assign size_in = (bus.i_element_size > SizeW'(MaxElems)) ? SizeW'(MaxElems)
                                                           : bus.i_element_size;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.i_start) state_d = (size_in == '0) ? StDone : StRead;
      StRead:  if (rd_cnt_q == size_q) state_d = StDrain;
      // Last write has been registered once nothing is left in the read pipeline.
      StDrain: if (!rd_valid_q && !data_valid_q) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Status outputs are decoded from the next state so they can be registered without lag.
  always_comb begin
    busy_d = (state_d == StRead) || (state_d == StDrain);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      size_q        <= '0;
      rd_cnt_q      <= '0;
      wr_addr_q     <= '0;
      rd_valid_q    <= 1'b0;
      data_valid_q  <= 1'b0;
      rd_addr_q     <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_out_q <= '0;
      wr_data_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      busy_q       <= busy_d;
      done_q       <= done_d;
      rd_valid_q   <= 1'b0;
      data_valid_q <= rd_valid_q;
      wr_en_q      <= data_valid_q;

      if (accept) begin
        size_q    <= size_in;
        wr_addr_q <= bus.i_bram_start_addr;
        if (size_in != '0) begin
          rd_addr_q  <= '0;
          rd_cnt_q   <= SizeW'(1);
          rd_valid_q <= 1'b1;
        end
      end else if (issue) begin
        rd_addr_q  <= rd_cnt_q[KERNEL_REG_ADDR_WIDTH-1:0];
        rd_cnt_q   <= rd_cnt_q + SizeW'(1);
        rd_valid_q <= 1'b1;
      end

      if (data_valid_q) begin
        wr_addr_out_q <= wr_addr_q;
        wr_data_q     <= bus.i_reg_data;
        wr_addr_q     <= (wr_addr_q == BRAM_ADDR_WIDTH'(BRAM_DEPTH - 1))
                         ? '0 : wr_addr_q + BRAM_ADDR_WIDTH'(1);
      end
    end
  end

  assign bus.o_reg_rd_addr  = rd_addr_q;
  assign bus.o_bram_wr_en   = wr_en_q;
  assign bus.o_bram_wr_addr = wr_addr_out_q;
  assign bus.o_bram_wr_data = wr_data_q;
  assign bus.o_busy         = busy_q;
  assign bus.o_done         = done_q;
  assign bus.o_state        = state_q;

endmodule
